// File: rtl/dram_ctrl_pkg.sv
// dram_ctrl_pkg: controller states, DRAM command encodings, timing constants
// and address helpers shared by dram_ctrl and dram_timer.
package dram_ctrl_pkg;

    localparam int ROW_W = 11;
    localparam int COL_W = 10;
    localparam int TMR_W = 7;

    localparam int T_RP  = 5;
    localparam int T_RCD = 5;
    localparam int T_WR  = 5;
    localparam int T_RTO = 64;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PRE      = 4'd1,
        ST_WAIT_RP  = 4'd2,
        ST_ACT      = 4'd3,
        ST_WAIT_RCD = 4'd4,
        ST_ACCESS   = 4'd5,
        ST_WAIT_RD  = 4'd6,
        ST_WAIT_WR  = 4'd7,
        ST_RESP     = 4'd8
    } state_t;

    // {RASn, CASn, WEn[3:0]}; a WR carries ~wstrb in its WEn field instead.
    localparam logic [5:0] CMD_NOP = 6'b11_1111;
    localparam logic [5:0] CMD_ACT = 6'b01_1111;
    localparam logic [5:0] CMD_RD  = 6'b10_1111;
    localparam logic [5:0] CMD_WR  = 6'b10_0000;
    localparam logic [5:0] CMD_PRE = 6'b01_0000;

    function automatic logic [ROW_W-1:0] addr_row(input logic [31:0] addr);
        return addr[22:12];
    endfunction

    function automatic logic [COL_W-1:0] addr_col(input logic [31:0] addr);
        return addr[11:2];
    endfunction

    // Timer load value that expires after the given number of cycles.
    function automatic logic [TMR_W-1:0] tmr_cycles(input int cycles);
        return TMR_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/dram_ctrl_timer.sv
// dram_timer: loadable down-counter that stops at zero; done_o is high while
// the count is zero. Shared by the precharge, activate, write and read-timeout waits.
module dram_timer
    import dram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             done_o
);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/dram_ctrl.sv
// dram_ctrl: single-word open-row DRAM controller (PRE/ACT/RD/WR sequencing, one
// response per request). Define DRAM_PERF_EN to add the perf_hit/perf_miss counters.
module dram_ctrl
    import dram_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        DRAM_CSn,
    output logic [3:0]  DRAM_WEn,
    output logic        DRAM_RASn,
    output logic        DRAM_CASn,
    output logic [10:0] DRAM_A,
    output logic [31:0] DRAM_D,
    input  logic [31:0] DRAM_Q,
    input  logic        DRAM_valid
`ifdef DRAM_PERF_EN
    ,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss
`endif
);

    state_t             state_q, state_d;
    logic               hs;
    logic               row_hit;

    logic               wr_q, wr_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;

    logic               row_open_q, row_open_d;
    logic [ROW_W-1:0]   open_row_q, open_row_d;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_done;

    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_write_q, rsp_write_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               csn_q;
    logic [5:0]         cmd_q, cmd_d;
    logic [10:0]        a_q, a_d;
    logic [31:0]        d_q, d_d;

    logic               unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:23], req_addr[1:0]};

    // Handshake: a request transfers on a rising edge where req_valid and req_ready
    // are both high; req_ready is high only in IDLE, so no request is ever stalled mid-flight.
    always_comb begin
        hs      = req_valid && req_ready_q && (state_q == ST_IDLE);
        row_hit = row_open_q && (addr_row(req_addr) == open_row_q);
        wr_d    = hs ? req_write           : wr_q;
        row_d   = hs ? addr_row(req_addr)  : row_q;
        col_d   = hs ? addr_col(req_addr)  : col_q;
        wdata_d = hs ? req_wdata           : wdata_q;
        wstrb_d = hs ? req_wstrb           : wstrb_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    if (row_hit)         state_d = ST_ACCESS;
                    else if (row_open_q) state_d = ST_PRE;
                    else                 state_d = ST_ACT;
                end
            end
            ST_PRE:      state_d = ST_WAIT_RP;
            ST_WAIT_RP:  if (tmr_done) state_d = ST_ACT;
            ST_ACT:      state_d = ST_WAIT_RCD;
            ST_WAIT_RCD: if (tmr_done) state_d = ST_ACCESS;
            ST_ACCESS:   state_d = wr_q ? ST_WAIT_WR : ST_WAIT_RD;
            ST_WAIT_RD:  if (DRAM_valid || tmr_done) state_d = ST_RESP;
            ST_WAIT_WR:  if (tmr_done) state_d = ST_RESP;
            ST_RESP:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // The timer is loaded on entry to a command state, so it counts from the command cycle.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state_d != state_q) begin
            unique case (state_d)
                ST_PRE: begin
                    tmr_load = 1'b1;
                    tmr_val  = tmr_cycles(T_RP);
                end
                ST_ACT: begin
                    tmr_load = 1'b1;
                    tmr_val  = tmr_cycles(T_RCD);
                end
                ST_ACCESS: begin
                    tmr_load = 1'b1;
                    tmr_val  = wr_d ? tmr_cycles(T_WR) : tmr_cycles(T_RTO);
                end
                default: begin
                    tmr_load = 1'b0;
                    tmr_val  = '0;
                end
            endcase
        end
    end

    dram_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Pin values are decoded from the next state so each command appears in its own state's cycle.
    always_comb begin
        cmd_d      = CMD_NOP;
        a_d        = '0;
        d_d        = '0;
        row_open_d = row_open_q;
        open_row_d = open_row_q;
        unique case (state_d)
            ST_PRE: begin
                cmd_d      = CMD_PRE;
                a_d        = open_row_q;
                row_open_d = 1'b0;
            end
            ST_ACT: begin
                cmd_d      = CMD_ACT;
                a_d        = row_d;
                row_open_d = 1'b1;
                open_row_d = row_d;
            end
            ST_ACCESS: begin
                a_d = {1'b0, col_d};
                if (wr_d) begin
                    cmd_d = {CMD_WR[5:4], ~wstrb_d};
                    d_d   = wdata_d;
                end else begin
                    cmd_d = CMD_RD;
                end
            end
            default: begin
                cmd_d = CMD_NOP;
            end
        endcase
    end

    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        rsp_write_d = (state_d == ST_RESP) && wr_q;
        rsp_err_d   = (state_q == ST_WAIT_RD) && !DRAM_valid && tmr_done;
        rsp_rdata_d = ((state_q == ST_WAIT_RD) && DRAM_valid) ? DRAM_Q : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_q       <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            row_open_q <= 1'b0;
            open_row_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            row_open_q <= row_open_d;
            open_row_q <= open_row_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            csn_q       <= 1'b1;
            cmd_q       <= CMD_NOP;
            a_q         <= '0;
            d_q         <= '0;
        end else begin
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            csn_q       <= 1'b0;
            cmd_q       <= cmd_d;
            a_q         <= a_d;
            d_q         <= d_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign DRAM_CSn  = csn_q;
    assign DRAM_RASn = cmd_q[5];
    assign DRAM_CASn = cmd_q[4];
    assign DRAM_WEn  = cmd_q[3:0];
    assign DRAM_A    = a_q;
    assign DRAM_D    = d_q;

`ifdef DRAM_PERF_EN
    logic [31:0] perf_hit_q;
    logic [31:0] perf_miss_q;

    // Saturating counters; a request with no row open counts as a miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else if (hs) begin
            if (row_hit) begin
                if (perf_hit_q != 32'hFFFF_FFFF) perf_hit_q <= perf_hit_q + 32'd1;
            end else begin
                if (perf_miss_q != 32'hFFFF_FFFF) perf_miss_q <= perf_miss_q + 32'd1;
            end
        end
    end

    assign perf_hit  = perf_hit_q;
    assign perf_miss = perf_miss_q;
`endif

endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: directed and randomized requests against a transaction-level model
// of the open-row policy; DRAM read data and valid timing are driven by the bench.
module tb_dram_ctrl;

    localparam int P_RP  = 5;
    localparam int P_RCD = 5;
    localparam int P_WR  = 5;
    localparam int P_RTO = 64;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        DRAM_CSn;
    logic [3:0]  DRAM_WEn;
    logic        DRAM_RASn;
    logic        DRAM_CASn;
    logic [10:0] DRAM_A;
    logic [31:0] DRAM_D;
    logic [31:0] DRAM_Q;
    logic        DRAM_valid;
`ifdef DRAM_PERF_EN
    logic [31:0] perf_hit;
    logic [31:0] perf_miss;
`endif

    dram_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_write  (rsp_write),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .DRAM_CSn   (DRAM_CSn),
        .DRAM_WEn   (DRAM_WEn),
        .DRAM_RASn  (DRAM_RASn),
        .DRAM_CASn  (DRAM_CASn),
        .DRAM_A     (DRAM_A),
        .DRAM_D     (DRAM_D),
        .DRAM_Q     (DRAM_Q),
        .DRAM_valid (DRAM_valid)
`ifdef DRAM_PERF_EN
        ,
        .perf_hit   (perf_hit),
        .perf_miss  (perf_miss)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state and reference model of the open row
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    bit          m_open;
    logic [10:0] m_row;
    int          m_hits;
    int          m_miss;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {pad, cycle, RASn, CASn, WEn, A, D}
    function automatic logic [63:0] pk(input int cyc, input logic [5:0] cmd,
                                       input logic [10:0] a, input logic [31:0] d);
        return {7'd0, 8'(cyc), cmd, a, d};
    endfunction

    task automatic reset_checks();
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_write", 64'(rsp_write), 64'd0);
        check_eq("rst_rsp_err",   64'(rsp_err),   64'd0);
        check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check_eq("rst_csn",       64'(DRAM_CSn),  64'd1);
        check_eq("rst_rasn",      64'(DRAM_RASn), 64'd1);
        check_eq("rst_casn",      64'(DRAM_CASn), 64'd1);
        check_eq("rst_wen",       64'(DRAM_WEn),  64'hF);
        check_eq("rst_a",         64'(DRAM_A),    64'd0);
        check_eq("rst_d",         64'(DRAM_D),    64'd0);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_csn",   64'(DRAM_CSn),  64'd0);
        check_eq("post_rst_ready", 64'(req_ready), 64'd1);
    endtask

    // One request: k = DRAM_valid delay after RD (0 = never), rst_mid = reset in WAIT_RCD.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int k, input bit rst_mid);
        logic [10:0] row;
        logic [9:0]  col;
        logic [31:0] exp_data;
        logic [63:0] last;
        bit          hit;
        bit          csn_bad;
        bit          rdy_bad;
        bit          got_write;
        bit          got_err;
        logic [31:0] got_data;
        int          pre_c, act_c, acc_c, rsp_c, rd_c, got_c, rst_at, t, nmin;

        row = addr[22:12];
        col = addr[11:2];
        exp_q.delete();
        obs_q.delete();
        pre_c = 0;
        act_c = 0;
        hit   = 1'b0;
        if (m_open && row == m_row) begin
            hit   = 1'b1;
            acc_c = 1;
        end else if (!m_open) begin
            act_c = 1;
            acc_c = 1 + P_RCD;
        end else begin
            pre_c = 1;
            act_c = 1 + P_RP;
            acc_c = act_c + P_RCD;
        end
        if (hit) m_hits++;
        else     m_miss++;
        if (pre_c != 0) exp_q.push_back(pk(pre_c, 6'b01_0000, m_row, 32'h0));
        if (act_c != 0) exp_q.push_back(pk(act_c, 6'b01_1111, row, 32'h0));
        exp_q.push_back(pk(acc_c, wr ? {2'b10, ~wstrb} : 6'b10_1111, {1'b0, col},
                           wr ? wdata : 32'h0));
        m_open = 1'b1;
        m_row  = row;
        if (wr)          rsp_c = acc_c + P_WR;
        else if (k == 0) rsp_c = acc_c + P_RTO;
        else             rsp_c = acc_c + k + 1;
        rst_at = (rst_mid && act_c != 0) ? act_c + 2 : 0;

        // Driver: wait for ready, present the request for exactly one edge
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("ready_wait", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;

        exp_data  = 32'h0;
        got_c     = 0;
        rd_c      = 0;
        csn_bad   = 1'b0;
        rdy_bad   = 1'b0;
        got_write = 1'b0;
        got_err   = 1'b0;
        got_data  = 32'h0;
        for (int n = 1; n <= 200 && got_c == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req_valid = 1'b0;
                req_write = 1'($urandom_range(0, 1));
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_wstrb = 4'($urandom_range(0, 15));
            end
            if (DRAM_CSn)  csn_bad = 1'b1;
            if (req_ready) rdy_bad = 1'b1;
            if (!DRAM_RASn || !DRAM_CASn || DRAM_WEn != 4'hF) begin
                obs_q.push_back(pk(n, {DRAM_RASn, DRAM_CASn, DRAM_WEn}, DRAM_A,
                                   (wr && !DRAM_CASn) ? DRAM_D : 32'h0));
                if (!wr && DRAM_RASn && !DRAM_CASn && rd_c == 0) rd_c = n;
            end
            if (rsp_valid) begin
                got_c     = n;
                got_write = rsp_write;
                got_err   = rsp_err;
                got_data  = rsp_rdata;
            end
            // DRAM side: noise on valid wherever the controller must ignore it
            DRAM_Q = $urandom;
            if (wr || rd_c == 0) begin
                DRAM_valid = 1'($urandom_range(0, 1));
            end else if (k != 0 && n == rd_c + k) begin
                DRAM_valid = 1'b1;
                exp_data   = DRAM_Q;
            end else begin
                DRAM_valid = 1'b0;
            end
            if (rst_at != 0 && n == rst_at) begin
                DRAM_valid = 1'b0;
                rst_n      = 1'b0;
                #1;
                reset_checks();
                m_open = 1'b0;
                m_hits = 0;
                m_miss = 0;
                release_reset();
                break;
            end
        end
        DRAM_valid = 1'b0;

        if (rst_at != 0) begin
            while (exp_q.size() > 0) begin
                last = exp_q[exp_q.size()-1];
                if (int'(last[56:49]) > rst_at) void'(exp_q.pop_back());
                else break;
            end
        end
        check_eq("ncmd", 64'(obs_q.size()), 64'(exp_q.size()));
        nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) check_eq("cmd", obs_q[i], exp_q[i]);
        check_eq("csn_low",    64'(csn_bad), 64'd0);
        check_eq("busy_ready", 64'(rdy_bad), 64'd0);

        if (rst_at == 0) begin
            check_eq("rsp_cycle", 64'(got_c),     64'(rsp_c));
            check_eq("rsp_write", 64'(got_write), 64'(wr));
            check_eq("rsp_err",   64'(got_err),   64'(!wr && k == 0));
            if (!wr) check_eq("rsp_rdata", 64'(got_data), 64'(exp_data));
            @(negedge clk);
            check_eq("idle_ready", 64'(req_ready), 64'd1);
            check_eq("rsp_pulse",  64'(rsp_valid), 64'd0);
        end
    endtask

    initial begin
        logic [10:0] rows [4];
        logic [10:0] r;
        logic [31:0] a;
        int          k;

        rows[0] = 11'h000;
        rows[1] = 11'h001;
        rows[2] = 11'h040;
        rows[3] = 11'h7FF;
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_wstrb  = 4'h0;
        DRAM_Q     = 32'h0;
        DRAM_valid = 1'b0;
        m_open     = 1'b0;
        m_row      = 11'h0;
        m_hits     = 0;
        m_miss     = 0;

        #2 rst_n = 1'b0;
        #1 reset_checks();
        release_reset();

        do_txn(1'b0, 32'h0004_0000, 32'h0,         4'h0,    3, 1'b0);
        do_txn(1'b1, 32'h0004_0004, 32'hDEADBEEF,  4'b0011, 0, 1'b0);
        do_txn(1'b0, 32'h0010_0000, 32'h0,         4'h0,    5, 1'b0);
        do_txn(1'b0, 32'h0010_0008, 32'h0,         4'h0,    0, 1'b0);
        do_txn(1'b0, 32'h0004_0008, 32'h0,         4'h0,    2, 1'b1);
        do_txn(1'b0, 32'h0010_0000, 32'h0,         4'h0,    4, 1'b0);
        do_txn(1'b1, 32'h0010_0010, $urandom,      4'b0000, 0, 1'b0);
        do_txn(1'b1, 32'h0000_0FFC, $urandom,      4'hF,    0, 1'b0);
        do_txn(1'b0, 32'h0000_0000, 32'h0,         4'h0,    1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r = rows[$urandom_range(0, 3)];
            a = {9'($urandom_range(0, 511)), r, 10'($urandom_range(0, 1023)),
                 2'($urandom_range(0, 3))};
            k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 10);
            do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), k, 1'b0);
        end

`ifdef DRAM_PERF_EN
        check_eq("perf_hit",  64'(perf_hit),  64'(m_hits));
        check_eq("perf_miss", 64'(perf_miss), 64'(m_miss));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
